// File: rtl/slow_fast_capture_sync.sv
// Multi-channel toggle-handshake capture from a slow/asynchronous source into
// the clk domain. Each channel synchronizes its request toggle, detects level
// changes, captures the held source word, returns an acknowledge toggle and
// keeps a capture counter plus an idle (stale) indicator.
module slow_fast_capture_sync #(
  parameter int WIDTH        = 12,
  parameter int CHANNELS     = 2,
  parameter int STAGES       = 2,
  parameter int STALE_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       src_toggle,
  input  logic [CHANNELS*WIDTH-1:0] src_data,
  output logic [CHANNELS-1:0]       dst_ack,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       data_valid,
  output logic [CHANNELS-1:0]       data_stale,
  output logic [CHANNELS*8-1:0]     update_count
);

  // Blanking lasts long enough for a level present at reset release to reach
  // the last sync stage and be copied into prev before detection is enabled.
  localparam int BLANK_CYCLES = STAGES + 1;
  localparam int BLANK_W      = $clog2(BLANK_CYCLES + 1);
  localparam int STALE_W      = $clog2(STALE_CYCLES + 1);

  logic [BLANK_W-1:0] blank_cnt_reg;
  logic [BLANK_W-1:0] blank_cnt_next;
  logic               blanking;
  logic               blank_last;

  assign blanking   = (blank_cnt_reg != BLANK_W'(BLANK_CYCLES));
  assign blank_last = (blank_cnt_reg == BLANK_W'(BLANK_CYCLES - 1));

  // Advance the post-reset blanking counter until it parks at its terminal value
  always_comb begin
    blank_cnt_next = blank_cnt_reg;
    if (blanking) begin
      blank_cnt_next = blank_cnt_reg + BLANK_W'(1);
    end
  end

  // Blanking counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt_reg <= '0;
    end else begin
      blank_cnt_reg <= blank_cnt_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_ch
      logic [STAGES-1:0]  sync_reg;
      logic               prev_reg;
      logic               ack_reg;
      logic               valid_reg;
      logic [WIDTH-1:0]   data_reg;
      logic [7:0]         count_reg;
      logic [STALE_W-1:0] stale_cnt_reg;
      logic [STALE_W-1:0] stale_cnt_next;
      logic               sync_last;
      logic               capture;

      assign sync_last = sync_reg[STAGES-1];
      // Suppressing a capture right after another keeps data_valid a
      // single-cycle pulse even if the source toggles faster than allowed.
      assign capture   = ~blanking & (sync_last ^ prev_reg) & ~valid_reg;

      // Synchronizer chain and edge-detect history; prev follows even while blanking
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[STAGES-2:0], src_toggle[gi]};
          prev_reg <= sync_last;
        end
      end

      // Capture the source word, pulse valid, count, and return the acknowledge
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          ack_reg   <= 1'b0;
          count_reg <= '0;
        end else begin
          valid_reg <= capture;
          if (capture) begin
            data_reg  <= src_data[gi*WIDTH +: WIDTH];
            ack_reg   <= sync_last;
            count_reg <= count_reg + 8'd1;
          end else if (blank_last) begin
            // Adopt whatever level the source left behind without capturing
            ack_reg <= sync_last;
          end
        end
      end

      // Idle counter: restart on capture, hold during blanking, saturate at the limit
      always_comb begin
        stale_cnt_next = stale_cnt_reg;
        if (capture) begin
          stale_cnt_next = '0;
        end else if (!blanking && (stale_cnt_reg != STALE_W'(STALE_CYCLES))) begin
          stale_cnt_next = stale_cnt_reg + STALE_W'(1);
        end
      end

      // Idle counter register
      always_ff @(posedge clk) begin
        if (reset) begin
          stale_cnt_reg <= '0;
        end else begin
          stale_cnt_reg <= stale_cnt_next;
        end
      end

      assign dst_ack[gi]                 = ack_reg;
      assign data_out[gi*WIDTH +: WIDTH] = data_reg;
      assign data_valid[gi]              = valid_reg;
      assign data_stale[gi]              = (stale_cnt_reg == STALE_W'(STALE_CYCLES));
      assign update_count[gi*8 +: 8]     = count_reg;
    end
  endgenerate

endmodule

// File: tb/tb_slow_fast_capture_sync.sv
// Self-checking bench for slow_fast_capture_sync (WIDTH=12, CHANNELS=2,
// STAGES=2, STALE_CYCLES=16). Captures are checked by a per-channel scoreboard
// fed when each toggle is driven; the main traffic comes from a vector table.
module tb_slow_fast_capture_sync;

  localparam int W  = 12;
  localparam int NC = 2;

  logic          clk;
  logic          reset;
  logic [NC-1:0] src_toggle;
  logic [NC*W-1:0] src_data;
  logic [NC-1:0] dst_ack;
  logic [NC*W-1:0] data_out;
  logic [NC-1:0] data_valid;
  logic [NC-1:0] data_stale;
  logic [NC*8-1:0] update_count;

  slow_fast_capture_sync #(
    .WIDTH(W), .CHANNELS(NC), .STAGES(2), .STALE_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .src_toggle(src_toggle), .src_data(src_data),
    .dst_ack(dst_ack), .data_out(data_out), .data_valid(data_valid),
    .data_stale(data_stale), .update_count(update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [W-1:0] data;
    logic [7:0] cnt;
    logic       ack;
  } exp_t;

  typedef struct {
    logic [1:0]   mask;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   ack;
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[6];
  logic [7:0]   exp_cnt[NC];
  logic [W-1:0] last_data[NC];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sb_size(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t sb_pop(input int c);
    if (c == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic sb_push(input int c, input exp_t e);
    if (c == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // One clock: count the edge, then sample at the falling edge and score captures
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      if (data_valid[c] === 1'b1) begin
        valid_seen++;
        if (sb_size(c) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid ch%0d: got valid=1 expected 0 (cycle %0d)", c, cyc);
        end else begin
          e = sb_pop(c);
          chk($sformatf("latency_ch%0d", c), cyc, e.cyc);
          chk($sformatf("data_ch%0d", c), data_out[c*W +: W], e.data);
          chk($sformatf("count_ch%0d", c), update_count[c*8 +: 8], e.cnt);
          chk($sformatf("ack_ch%0d", c), dst_ack[c], e.ack);
          $display("capture ch%0d data=%03h count=%0d cycle=%0d", c,
                   data_out[c*W +: W], update_count[c*8 +: 8], cyc);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int c = 0; c < NC; c++) begin
      exp_cnt[c]   = 8'd0;
      last_data[c] = '0;
    end
  endtask

  task automatic do_reset(input logic [1:0] tog);
    src_toggle = tog;
    reset = 1'b1;
    clear_model();
    ticks(2);
    reset = 1'b0;
    ticks(5);
  endtask

  // Flip the toggles in mask with their data, expect capture 3 cycles later
  task automatic send(input logic [1:0] mask, input logic [W-1:0] d0, input logic [W-1:0] d1);
    exp_t e;
    int n;
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        src_data[c*W +: W] = (c == 0) ? d0 : d1;
        src_toggle[c] = ~src_toggle[c];
        exp_cnt[c] = exp_cnt[c] + 8'd1;
        last_data[c] = (c == 0) ? d0 : d1;
        e.cyc  = cyc + 3;
        e.data = last_data[c];
        e.cnt  = exp_cnt[c];
        e.ack  = src_toggle[c];
        sb_push(c, e);
      end
    end
    n = 0;
    do begin
      tick();
      n++;
    end while ((dst_ack !== src_toggle) && (n < 20));
    if (dst_ack !== src_toggle) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got dst_ack=%b expected %b", dst_ack, src_toggle);
    end
    ticks(4);
  endtask

  initial begin
    int k;
    int vs;
    int n;
    exp_t e;

    vecs[0] = '{2'b01, 12'h0A5, 12'h000, 2'b01, 8'd1, 8'd0};
    vecs[1] = '{2'b11, 12'h123, 12'hFED, 2'b10, 8'd2, 8'd1};
    vecs[2] = '{2'b10, 12'h000, 12'h555, 2'b00, 8'd2, 8'd2};
    vecs[3] = '{2'b01, 12'hFFF, 12'h000, 2'b01, 8'd3, 8'd2};
    vecs[4] = '{2'b11, 12'h000, 12'hABC, 2'b10, 8'd4, 8'd3};
    vecs[5] = '{2'b10, 12'h000, 12'h001, 2'b00, 8'd4, 8'd4};

    reset = 1'b1;
    src_toggle = '0;
    src_data = '0;
    clear_model();
    ticks(3);
    chk("reset_ack", dst_ack, 0);
    chk("reset_data", data_out, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_stale", data_stale, 0);
    chk("reset_count", update_count, 0);

    // Stale flag appears exactly 16 cycles after the 3-cycle blanking window
    reset = 1'b0;
    k = cyc;
    while (cyc < k + 18) tick();
    chk("stale_early", data_stale, 2'b00);
    tick();
    chk("stale_set", data_stale, 2'b11);
    src_data[0 +: W] = 12'h3C3;
    src_toggle[0] = 1'b1;
    exp_cnt[0] = 8'd1;
    e.cyc = cyc + 3; e.data = 12'h3C3; e.cnt = 8'd1; e.ack = 1'b1;
    sb_push(0, e);
    n = 0;
    do begin
      tick();
      n++;
    end while ((data_valid[0] !== 1'b1) && (n < 10));
    chk("stale_valid_seen", data_valid[0], 1'b1);
    chk("stale_clear_ch0", data_stale[0], 1'b0);
    chk("stale_keep_ch1", data_stale[1], 1'b1);
    ticks(4);

    // Toggle left high across reset must not capture; ack adopts it
    src_toggle = 2'b11;
    reset = 1'b1;
    clear_model();
    ticks(2);
    vs = valid_seen;
    reset = 1'b0;
    ticks(8);
    chk("held_high_no_valid", valid_seen, vs);
    chk("held_high_ack", dst_ack, 2'b11);
    chk("held_high_count", update_count, 0);
    send(2'b01, 12'h777, 12'h000);
    chk("held_high_next_data", data_out[0 +: W], 12'h777);

    // Table-driven traffic from a clean reset
    do_reset(2'b00);
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].mask, vecs[i].d0, vecs[i].d1);
      $display("vector %0d mask=%b ack=%b count0=%0d count1=%0d", i, vecs[i].mask,
               dst_ack, update_count[7:0], update_count[15:8]);
      chk($sformatf("vec%0d_ack", i), dst_ack, vecs[i].ack);
      chk($sformatf("vec%0d_cnt0", i), update_count[7:0], vecs[i].cnt0);
      chk($sformatf("vec%0d_cnt1", i), update_count[15:8], vecs[i].cnt1);
      chk($sformatf("vec%0d_hold0", i), data_out[0 +: W], last_data[0]);
      chk($sformatf("vec%0d_hold1", i), data_out[W +: W], last_data[1]);
    end

    // 256 handshakes on ch1: counter wraps back to zero
    do_reset(2'b00);
    for (int i = 0; i < 256; i++) begin
      send(2'b10, 12'h000, W'(i * 7 + 3));
      if (i == 254) chk("wrap_255", update_count[15:8], 8'd255);
    end
    chk("wrap_zero", update_count[15:8], 8'd0);
    chk("wrap_ch0_idle", update_count[7:0], 8'd0);
    chk("wrap_last_data", data_out[W +: W], W'(255 * 7 + 3));

    // Reset one cycle after a toggle change discards the pending capture
    src_data[0 +: W] = 12'h9A9;
    src_toggle[0] = ~src_toggle[0];
    tick();
    reset = 1'b1;
    clear_model();
    vs = valid_seen;
    tick();
    chk("midrst_valid", data_valid, 0);
    chk("midrst_ack", dst_ack, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_count", update_count, 0);
    chk("midrst_stale", data_stale, 0);
    ticks(3);
    reset = 1'b0;
    ticks(8);
    chk("midrst_no_valid", valid_seen, vs);

    chk("sb_empty_ch0", q0.size(), 0);
    chk("sb_empty_ch1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slow_fast_capture_sync.md
SLOW_FAST_CAPTURE_SYNC -- requirements
Module: slow_fast_capture_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, bits per channel data word.
REQ-002 The block SHALL have parameter CHANNELS, default 2, number of independent channels (>=1).
REQ-003 The block SHALL have parameter STAGES, default 2, synchronizer flop depth per channel (>=2).
REQ-004 The block SHALL have parameter STALE_CYCLES, default 1024, idle cycles before a channel is flagged stale (>=1).
REQ-005 The block SHALL have port clk, input, 1, sole (fast, destination) clock; one clock, all logic on rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port src_toggle, input, CHANNELS, per-channel request toggle, asynchronous to clk.
REQ-008 The block SHALL have port src_data, input, CHANNELS*WIDTH, channel c at bits [c*WIDTH +: WIDTH], held stable by source from toggle change until matching dst_ack.
REQ-009 The block SHALL have port dst_ack, output, CHANNELS, per-channel acknowledge toggle returned to source.
REQ-010 The block SHALL have port data_out, output, CHANNELS*WIDTH, last captured word per channel, same packing as src_data.
REQ-011 The block SHALL have port data_valid, output, CHANNELS, one-cycle pulse per new capture.
REQ-012 The block SHALL have port data_stale, output, CHANNELS, level, high when channel idle >= STALE_CYCLES.
REQ-013 The block SHALL have port update_count, output, CHANNELS*8, per-channel capture counter.

Function
REQ-014 Each channel SHALL pass src_toggle[c] through a STAGES-deep flop chain; only the last stage feeds logic.
REQ-015 An edge SHALL be detected when last sync stage differs from a registered copy of it (prev).
REQ-016 On the edge cycle the channel SHALL register src_data slice into data_out, pulse data_valid for exactly the following cycle (aligned with new data_out), and toggle dst_ack.
REQ-017 Latency from src_toggle change to data_valid high SHALL be STAGES+1 clk cycles (change presented before an edge).
REQ-018 data_out SHALL hold its value between captures; no capture SHALL occur without a detected edge.
REQ-019 update_count slice SHALL increment by 1 per capture, wrap 255 -> 0, no saturation.
REQ-020 Each channel SHALL have a stale counter: cleared to 0 on capture, else incremented, saturating at STALE_CYCLES; data_stale = (counter == STALE_CYCLES).
REQ-021 Capture and data_stale clear SHALL occur in the same cycle as data_valid; stale counter restarts from 0 that cycle.
REQ-022 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each capture in the same cycle.
REQ-023 Source SHALL hold each toggle level >= 2*STAGES+2 cycles (guaranteed by waiting for dst_ack); faster toggling is out of contract, block SHALL never produce X or multi-cycle data_valid.

Reset
REQ-024 While reset high: sync chains, prev, dst_ack, data_out, data_valid, data_stale, update_count, stale counters SHALL all be 0.
REQ-025 For STAGES+1 cycles after reset deasserts (blanking), edge detection SHALL be suppressed; prev tracks sync stage.
REQ-026 At end of blanking dst_ack[c] SHALL be loaded with synchronized toggle value, with no data_valid, so a source toggle left at 1 causes no spurious capture.
REQ-027 Reset asserted mid-transfer SHALL discard any pending edge; no data_valid in the cycle following reset assertion.
REQ-028 Stale counters SHALL start counting after blanking; data_stale SHALL not assert earlier than STALE_CYCLES cycles after blanking ends.

Verification
REQ-029 Bench SHALL check: WIDTH=12, STAGES=2, ch0 data 12'h0A5 then toggle 0->1 -> data_valid[0] 3 cycles later for 1 cycle, data_out ch0=12'h0A5, dst_ack[0]=1, update_count ch0=1.
REQ-030 Bench SHALL check: both channels toggle same cycle with 12'h123 / 12'hFED -> both data_valid same cycle, correct slices, no cross-channel corruption.
REQ-031 Bench SHALL check: 256 handshakes on ch1 -> update_count ch1 wraps to 0, every data_out value matches the sent counting sequence.
REQ-032 Bench SHALL check: STALE_CYCLES=16, no toggles -> data_stale high exactly 16 cycles after blanking; one capture -> data_stale low in data_valid cycle.
REQ-033 Bench SHALL check: src_toggle held 1 across reset release -> no data_valid, dst_ack=1 after blanking; next toggle to 0 captures normally.
REQ-034 Bench SHALL check: reset asserted 1 cycle after toggle change -> no data_valid, all outputs 0 next cycle.
